sram_port_arbiter: RTL and testbench

Shares the single-port accelerator SRAM (ADDR_WIDTH_SRAM × DATA_WIDTH_SRAM, synchronous read, 1-cycle latency) among NUM_REQ requesters: ifmap-group fetch (0), filter fetch (1) and result writeback (2). It sits between the address generators / output buffer and the SRAM inside the datapath top. Arbitration is round-robin with bounded bursts, so a streaming requester keeps the port without bubbles but cannot starve the others.

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/sram_port_arbiter_rr_picker.sv | 29 ++
 rtl/sram_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and width helpers for the SRAM port arbiter.
package sram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned burst_width(input int unsigned m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_picker.sv
// Round-robin picker: first requester at or after start, skipping excluded ones.
module rr_picker #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  input  logic [NUM_REQ-1:0] excl,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  int unsigned idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(start) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!valid && req[idx] && !excl[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one synchronous single-port SRAM
// among NUM_REQ requesters; read data returns one cycle after grant.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 3,
  parameter int unsigned ADDR_WIDTH_SRAM = 8,
  parameter int unsigned DATA_WIDTH_SRAM = 16,
  parameter int unsigned MAX_BURST       = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ-1:0]                   we,
  input  logic [NUM_REQ*ADDR_WIDTH_SRAM-1:0]   addr,
  input  logic [NUM_REQ*DATA_WIDTH_SRAM-1:0]   wdata,
  output logic [NUM_REQ-1:0]                   gnt,
  output logic [NUM_REQ-1:0]                   rvalid,
  output logic [DATA_WIDTH_SRAM-1:0]           rdata,
  output logic                                 sram_en,
  output logic                                 sram_we,
  output logic [ADDR_WIDTH_SRAM-1:0]           sram_addr,
  output logic [DATA_WIDTH_SRAM-1:0]           sram_wdata,
  input  logic [DATA_WIDTH_SRAM-1:0]           sram_rdata
);

  localparam int unsigned REQ_IDX_W = idx_width(NUM_REQ);
  localparam int unsigned BURST_W   = burst_width(MAX_BURST);

  arb_state_e           state_q, state_d;
  logic [REQ_IDX_W-1:0] owner_q, owner_d;
  logic [REQ_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;

  logic [NUM_REQ-1:0]   owner_oh, pick_excl, pick_oh, gnt_int;
  logic [REQ_IDX_W-1:0] owner_next, pick_start, pick_idx;
  logic                 pick_valid, keep_owner, handover;

  // Picker inputs are resolved first so the handover pick is available in the same cycle.
  always_comb begin
    owner_oh           = '0;
    owner_oh[owner_q]  = 1'b1;
    owner_next         = (owner_q == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    keep_owner         = req[owner_q] &&
                         ((burst_cnt_q < BURST_W'(MAX_BURST)) || !(|(req & ~owner_oh)));
    handover           = (state_q == BUSY) && !keep_owner;
    pick_start         = handover ? owner_next : rr_ptr_q;
    pick_excl          = handover ? owner_oh : '0;
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (REQ_IDX_W)
  ) u_picker (
    .req   (req),
    .start (pick_start),
    .excl  (pick_excl),
    .pick  (pick_oh),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) pick_idx = REQ_IDX_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    gnt_int     = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_int     = pick_oh;
          state_d     = BUSY;
          owner_d     = pick_idx;
          burst_cnt_d = BURST_W'(1);
        end
      end
      BUSY: begin
        if (keep_owner) begin
          gnt_int     = owner_oh;
          burst_cnt_d = (burst_cnt_q < BURST_W'(MAX_BURST)) ? burst_cnt_q + 1'b1 : BURST_W'(1);
        end else begin
          rr_ptr_d = owner_next;
          if (pick_valid) begin
            gnt_int     = pick_oh;
            owner_d     = pick_idx;
            burst_cnt_d = BURST_W'(1);
          end else begin
            state_d     = IDLE;
            burst_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant is combinational from req, so it is forced low while reset is held.
  always_comb begin
    gnt        = rst ? '0 : gnt_int;
    sram_en    = |gnt;
    sram_we    = |(gnt & we);
    sram_addr  = '0;
    sram_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sram_addr  = addr[i*ADDR_WIDTH_SRAM +: ADDR_WIDTH_SRAM];
        sram_wdata = wdata[i*DATA_WIDTH_SRAM +: DATA_WIDTH_SRAM];
      end
    end
    rvalid_d = gnt & ~we;
  end

  assign rvalid = rvalid_q;
  assign rdata  = sram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      rvalid_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      rvalid_q    <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed, table-driven bench for sram_port_arbiter (3 requesters, burst 4).
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, we, gnt, rvalid;
  logic [23:0] addr;
  logic [47:0] wdata;
  logic [15:0] rdata, sram_rdata, sram_wdata;
  logic        sram_en, sram_we;
  logic [7:0]  sram_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int step_no = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .NUM_REQ         (3),
    .ADDR_WIDTH_SRAM (8),
    .DATA_WIDTH_SRAM (16),
    .MAX_BURST       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  typedef struct {
    logic [2:0] req;
    logic [2:0] we;
    logic [2:0] gnt;
    logic [2:0] rvalid;
    logic       swe;
    logic [7:0] saddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] r, input logic [2:0] w, input logic [2:0] g,
                     input logic [2:0] rv, input logic swe, input logic [7:0] sa);
    vec_t v;
    v.req = r; v.we = w; v.gnt = g; v.rvalid = rv; v.swe = swe; v.saddr = sa;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, step_no, act, exp);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, ".gnt"}, 32'(gnt), 32'h0);
    chk({nm, ".en"}, 32'(sram_en), 32'h0);
    chk({nm, ".we"}, 32'(sram_we), 32'h0);
    chk({nm, ".addr"}, 32'(sram_addr), 32'h0);
    chk({nm, ".wdata"}, 32'(sram_wdata), 32'h0);
  endtask

  initial begin
    rst = 1'b1; req = 3'b111; we = 3'b000;
    addr = {8'hC2, 8'hB1, 8'hA0};
    wdata = {16'h2222, 16'h1111, 16'h0000};
    sram_rdata = 16'h0;

    // Reset state with requests asserted
    repeat (2) @(negedge clk);
    #1;
    step_no = -1;
    chk_quiet("reset");
    chk("reset.rvalid", 32'(rvalid), 32'h0);
    @(negedge clk);
    rst = 1'b0; req = 3'b000;

    // Full-contention reads: bursts of 4 rotating 0,1,2,0
    add(3'b111, 3'b000, 3'b001, 3'b000, 1'b0, 8'hA0);
    add(3'b111, 3'b000, 3'b001, 3'b001, 1'b0, 8'hA0);
    add(3'b111, 3'b000, 3'b001, 3'b001, 1'b0, 8'hA0);
    add(3'b111, 3'b000, 3'b001, 3'b001, 1'b0, 8'hA0);
    add(3'b111, 3'b000, 3'b010, 3'b001, 1'b0, 8'hB1);
    add(3'b111, 3'b000, 3'b010, 3'b010, 1'b0, 8'hB1);
    add(3'b111, 3'b000, 3'b010, 3'b010, 1'b0, 8'hB1);
    add(3'b111, 3'b000, 3'b010, 3'b010, 1'b0, 8'hB1);
    add(3'b111, 3'b000, 3'b100, 3'b010, 1'b0, 8'hC2);
    add(3'b111, 3'b000, 3'b100, 3'b100, 1'b0, 8'hC2);
    add(3'b111, 3'b000, 3'b100, 3'b100, 1'b0, 8'hC2);
    add(3'b111, 3'b000, 3'b100, 3'b100, 1'b0, 8'hC2);
    add(3'b111, 3'b000, 3'b001, 3'b100, 1'b0, 8'hA0);
    add(3'b000, 3'b000, 3'b000, 3'b001, 1'b0, 8'h00);
    add(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 8'h00);
    // req[0] streaming, req[2] joins at cycle 2: handover at cycle 4 without a bubble
    add(3'b001, 3'b000, 3'b001, 3'b000, 1'b0, 8'hA0);
    add(3'b001, 3'b000, 3'b001, 3'b001, 1'b0, 8'hA0);
    add(3'b101, 3'b000, 3'b001, 3'b001, 1'b0, 8'hA0);
    add(3'b101, 3'b000, 3'b001, 3'b001, 1'b0, 8'hA0);
    add(3'b101, 3'b000, 3'b100, 3'b001, 1'b0, 8'hC2);
    add(3'b100, 3'b000, 3'b100, 3'b100, 1'b0, 8'hC2);
    add(3'b000, 3'b000, 3'b000, 3'b100, 1'b0, 8'h00);
    // Owner 0 drops after 2 grants; search restarts at 1 so 1 beats 2
    add(3'b011, 3'b010, 3'b001, 3'b000, 1'b0, 8'hA0);
    add(3'b011, 3'b010, 3'b001, 3'b001, 1'b0, 8'hA0);
    add(3'b110, 3'b010, 3'b010, 3'b001, 1'b1, 8'hB1);
    add(3'b000, 3'b010, 3'b000, 3'b000, 1'b0, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      step_no = i;
      req = vecs[i].req;
      we = vecs[i].we;
      sram_rdata = 16'hD000 + 16'(i);
      #1;
      chk("tbl.gnt", 32'(gnt), 32'(vecs[i].gnt));
      chk("tbl.rvalid", 32'(rvalid), 32'(vecs[i].rvalid));
      chk("tbl.sram_en", 32'(sram_en), 32'(|vecs[i].gnt));
      chk("tbl.sram_we", 32'(sram_we), 32'(vecs[i].swe));
      chk("tbl.sram_addr", 32'(sram_addr), 32'(vecs[i].saddr));
      if (vecs[i].rvalid != 3'b000) chk("tbl.rdata", 32'(rdata), 32'(16'hD000 + 16'(i)));
    end

    // Lone writer keeps the port across burst renewal
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      step_no = 100 + k;
      req = 3'b010; we = 3'b010;
      addr = '0; addr[15:8] = 8'h10 + 8'(k);
      wdata = '0; wdata[31:16] = 16'h5000 + 16'(k);
      #1;
      chk("wr.gnt", 32'(gnt), 32'h2);
      chk("wr.sram_we", 32'(sram_we), 32'h1);
      chk("wr.sram_addr", 32'(sram_addr), 32'(8'h10 + 8'(k)));
      chk("wr.sram_wdata", 32'(sram_wdata), 32'(16'h5000 + 16'(k)));
      chk("wr.rvalid", 32'(rvalid), 32'h0);
    end
    @(negedge clk);
    step_no = 110;
    req = 3'b000; we = 3'b000;
    #1;
    chk("wr_end.gnt", 32'(gnt), 32'h0);
    chk("wr_end.rvalid", 32'(rvalid), 32'h0);

    // Idle then a single read by requester 1
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      step_no = 200 + k;
      #1;
      chk("idle.sram_en", 32'(sram_en), 32'h0);
      chk("idle.gnt", 32'(gnt), 32'h0);
    end
    @(negedge clk);
    step_no = 205;
    req = 3'b010; addr = {8'h00, 8'h44, 8'h00};
    #1;
    chk("rd1.gnt", 32'(gnt), 32'h2);
    chk("rd1.sram_addr", 32'(sram_addr), 32'h44);
    chk("rd1.sram_we", 32'(sram_we), 32'h0);
    @(negedge clk);
    step_no = 206;
    req = 3'b000; sram_rdata = 16'h1234;
    #1;
    chk("rd1.rvalid", 32'(rvalid), 32'h2);
    chk("rd1.rdata", 32'(rdata), 32'h1234);
    @(negedge clk);
    step_no = 207;
    #1;
    chk("rd1.rvalid_clr", 32'(rvalid), 32'h0);

    // Read by 2 interrupted by reset: pending rvalid dropped, rr_ptr back to 0
    @(negedge clk);
    step_no = 300;
    req = 3'b100; addr = {8'h20, 8'h55, 8'h00};
    #1;
    chk("rst_rd.gnt", 32'(gnt), 32'h4);
    chk("rst_rd.sram_addr", 32'(sram_addr), 32'h20);
    @(negedge clk);
    step_no = 301;
    rst = 1'b1; sram_rdata = 16'hBEEF;
    #1;
    chk("rst_rd.rvalid", 32'(rvalid), 32'h0);
    chk_quiet("rst_mid");
    @(negedge clk);
    step_no = 302;
    #1;
    chk("rst_hold.rvalid", 32'(rvalid), 32'h0);
    chk_quiet("rst_hold");
    @(negedge clk);
    step_no = 303;
    rst = 1'b0; req = 3'b110;
    #1;
    chk("post_rst.gnt", 32'(gnt), 32'h2);
    chk("post_rst.sram_addr", 32'(sram_addr), 32'h55);
    @(negedge clk);
    step_no = 304;
    req = 3'b000;
    #1;
    chk("post_rst.rvalid", 32'(rvalid), 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
